// File: rtl/bit_sync_pkg.sv
// Shared receive/transmit clocking definitions: symbol rate defaults,
// the bit synchronizer state set and a phase tolerance helper.
package bit_sync_pkg;

  localparam int OSR_DEFAULT   = 128;
  localparam int CNT_W_DEFAULT = $clog2(OSR_DEFAULT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } bs_state_e;

  // True when a signed phase error lies inside the on-time window.
  function automatic logic within_tol(input int err, input int tol);
    return (err <= tol) && (err >= -tol);
  endfunction

endpackage

// File: rtl/bit_sync_if.sv
// Serial line in, recovered bit stream / symbol clock / lock out.
// master = bit_sync, slave = line driver plus downstream framing.
interface bit_sync_if;
  import bit_sync_pkg::*;

  logic din;
  logic enable;
  logic data_out;
  logic data_valid;
  logic clk_rec;
  logic locked;

  modport master (
    input  din,
    input  enable,
    output data_out,
    output data_valid,
    output clk_rec,
    output locked
  );

  modport slave (
    output din,
    output enable,
    input  data_out,
    input  data_valid,
    input  clk_rec,
    input  locked
  );

endinterface

// File: rtl/bit_sync_sync2_edge.sv
// sync2_edge: two-flop synchronizer for an asynchronous level plus a
// transition detector on the synchronized value.
module sync2_edge
  import bit_sync_pkg::*;
(
  input  logic clk_1,
  input  logic reset,
  input  logic async_in,
  output logic sync_pre,
  output logic edge_det
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic dly_q,  dly_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  always_ff @(posedge clk_1 or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  // sync_pre is the value sync_q takes next cycle; only feed it to flops.
  assign sync_pre = meta_q;
  assign edge_det = sync_q ^ dly_q;

endmodule

// File: rtl/bit_sync.sv
// bit_sync: oversampling bit synchronizer and symbol clock recoverer.
// A phase counter is nudged one cycle per edge toward the line transitions.
module bit_sync
  import bit_sync_pkg::*;
#(
  parameter int OSR      = OSR_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 8,
  parameter int MAX_RUN  = 32
) (
  input  logic       clk_1,
  input  logic       reset,
  bit_sync_if.master bus
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int RUN_W  = $clog2(MAX_RUN + 1);
  localparam logic [CNT_W-1:0]  PHASE_HALF = CNT_W'(OSR / 2);
  localparam logic [CNT_W-1:0]  PHASE_LAST = CNT_W'(OSR - 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX   = GOOD_W'(LOCK_CNT);
  localparam logic [RUN_W-1:0]  RUN_LAST   = RUN_W'(MAX_RUN - 1);

  bs_state_e         state_q, state_d;
  logic [CNT_W-1:0]  phase_q, phase_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic              locked_q, locked_d;
  logic              data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              clk_rec_q, clk_rec_d;
  logic              din_pre_s;
  logic              edge_s;
  int                phase_err;

  sync2_edge u_sync (
    .clk_1    (clk_1),
    .reset    (reset),
    .async_in (bus.din),
    .sync_pre (din_pre_s),
    .edge_det (edge_s)
  );

  // Next state, phase correction and lock/timeout bookkeeping.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    good_cnt_d = good_cnt_q;
    run_cnt_d  = run_cnt_q;
    // Reading the phase as two's complement gives p or p-OSR directly.
    phase_err  = int'($signed(phase_q));

    if (!bus.enable) begin
      state_d    = IDLE;
      phase_d    = '0;
      good_cnt_d = '0;
      run_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = ACQUIRE;
          phase_d    = '0;
          good_cnt_d = '0;
          run_cnt_d  = '0;
        end
        ACQUIRE: begin
          phase_d = '0;
          if (edge_s) begin
            // Hard alignment: the edge cycle itself is phase 0.
            state_d    = TRACK;
            phase_d    = CNT_W'(1);
            good_cnt_d = GOOD_W'(1);
            run_cnt_d  = '0;
          end else begin
            run_cnt_d = '0;
          end
        end
        TRACK: begin
          if (edge_s) begin
            run_cnt_d = '0;
            if (phase_err > 0) begin
              phase_d = phase_q;
            end else if (phase_err < 0) begin
              phase_d = phase_q + CNT_W'(2);
            end else begin
              phase_d = phase_q + CNT_W'(1);
            end
            if (within_tol(phase_err, TOL)) begin
              if (good_cnt_q != GOOD_MAX) begin
                good_cnt_d = good_cnt_q + GOOD_W'(1);
              end else begin
                good_cnt_d = good_cnt_q;
              end
            end else begin
              good_cnt_d = '0;
            end
          end else begin
            phase_d = phase_q + CNT_W'(1);
            if (phase_q == PHASE_LAST) begin
              if (run_cnt_q == RUN_LAST) begin
                state_d    = ACQUIRE;
                phase_d    = '0;
                run_cnt_d  = '0;
                good_cnt_d = '0;
              end else begin
                run_cnt_d = run_cnt_q + RUN_W'(1);
              end
            end else begin
              run_cnt_d = run_cnt_q;
            end
          end
        end
        default: begin
          state_d    = IDLE;
          phase_d    = '0;
          good_cnt_d = '0;
          run_cnt_d  = '0;
        end
      endcase
    end

    locked_d     = (good_cnt_d == GOOD_MAX);
    // Outputs are decoded from next state so the registers line up with phase_q.
    data_valid_d = (state_d == TRACK) && (phase_d == PHASE_HALF);
    clk_rec_d    = (state_d == TRACK) && phase_d[CNT_W-1];
    if (!bus.enable) begin
      data_out_d = 1'b0;
    end else if (data_valid_d) begin
      data_out_d = din_pre_s;
    end else begin
      data_out_d = data_out_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_1 or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      good_cnt_q   <= '0;
      run_cnt_q    <= '0;
      locked_q     <= 1'b0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      clk_rec_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      good_cnt_q   <= good_cnt_d;
      run_cnt_q    <= run_cnt_d;
      locked_q     <= locked_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      clk_rec_q    <= clk_rec_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.clk_rec    = clk_rec_q;
  assign bus.locked     = locked_q;

endmodule

// File: tb/tb_bit_sync.sv
// Randomized bench for bit_sync against a time-based reference model
// (phase is derived from the cycle count minus a moving alignment time).
module tb_bit_sync;

  localparam int OSR     = 128;
  localparam int HALF    = OSR / 2;
  localparam int TOL     = 2;
  localparam int LOCK_N  = 8;
  localparam int MAX_RUN = 32;
  localparam int M_IDLE  = 0;
  localparam int M_ACQ   = 1;
  localparam int M_TRK   = 2;

  logic clk_1   = 1'b0;
  logic reset   = 1'b0;
  logic rst_drv = 1'b0;

  bit_sync_if bus ();

  bit_sync #(
    .OSR      (OSR),
    .CNT_W    (7),
    .TOL      (TOL),
    .LOCK_CNT (LOCK_N),
    .MAX_RUN  (MAX_RUN)
  ) dut (
    .clk_1 (clk_1),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_1 = ~clk_1;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   t0;
  int   m_mode, m_align, m_good, m_run;
  logic m_locked, m_dout, m_valid, m_clk;
  logic h1, h2, h3;
  logic lvl;
  int   dv_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int wrap(input int x);
    return ((x % OSR) + OSR) % OSR;
  endfunction

  task automatic model_clear();
    m_mode = M_IDLE; m_align = 0; m_good = 0; m_run = 0;
    m_locked = 1'b0; m_dout = 1'b0; m_valid = 1'b0; m_clk = 1'b0;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
  endtask

  // h1/h2/h3 hold the line level one, two and three cycles back.
  task automatic model_step(input logic d, input logic en);
    logic seen;
    int   p, e, ph;
    seen = (h2 != h3);
    if (!en) begin
      m_mode = M_IDLE; m_good = 0; m_run = 0; m_dout = 1'b0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_ACQ;
    end else if (m_mode == M_ACQ) begin
      if (seen) begin
        m_mode = M_TRK; m_align = cyc - 1; m_good = 1; m_run = 0;
      end
    end else begin
      p = wrap(cyc - 1 - m_align);
      if (seen) begin
        e = (p < HALF) ? p : p - OSR;
        if (e > 0) m_align = m_align + 1;
        else if (e < 0) m_align = m_align - 1;
        if (e >= -TOL && e <= TOL) m_good = (m_good < LOCK_N) ? m_good + 1 : LOCK_N;
        else m_good = 0;
        m_run = 0;
      end else if (p == OSR - 1) begin
        m_run = m_run + 1;
        if (m_run == MAX_RUN) begin
          m_mode = M_ACQ; m_run = 0; m_good = 0;
        end
      end
    end
    m_locked = (m_good == LOCK_N);
    if (m_mode == M_TRK) begin
      ph = wrap(cyc - m_align);
      m_valid = (ph == HALF);
      m_clk = (ph >= HALF);
    end else begin
      m_valid = 1'b0;
      m_clk = 1'b0;
    end
    if (m_valid) m_dout = h1;
    h3 = h2; h2 = h1; h1 = d;
  endtask

  task automatic tick(input logic d, input logic en);
    @(negedge clk_1);
    reset = rst_drv;
    bus.din = d;
    bus.enable = en;
    lvl = d;
    @(posedge clk_1);
    cyc++;
    if (!rst_drv) model_clear();
    else model_step(d, en);
    #1;
    chk("data_valid", bus.data_valid, m_valid);
    chk("data_out", bus.data_out, m_dout);
    chk("clk_rec", bus.clk_rec, m_clk);
    chk("locked", bus.locked, m_locked);
    if (bus.data_valid === 1'b1) dv_q.push_back(cyc);
  endtask

  task automatic send_bit(input logic v, input int len);
    repeat (len) tick(v, 1'b1);
  endtask

  task automatic check_acq(input string tag, input int nbits);
    chk({tag, "_dv_count"}, dv_q.size(), nbits);
    if (dv_q.size() >= 2) begin
      chk({tag, "_first_dv"}, dv_q[0] - t0, 65);
      chk({tag, "_dv_period"}, dv_q[1] - dv_q[0], OSR);
    end
  endtask

  initial begin
    logic nv;
    bus.din = 1'b0;
    bus.enable = 1'b0;
    lvl = 1'b0;
    model_clear();

    // Reset held low with a busy line, then idle with enable low.
    repeat (6) tick(1'($urandom_range(0, 1)), 1'b1);
    rst_drv = 1'b1;
    repeat (200) tick(1'($urandom_range(0, 1)), 1'b0);
    repeat (6) tick(1'b0, 1'b0);

    // Acquisition on an ideal 1010 pattern.
    dv_q.delete();
    t0 = cyc + 1;
    for (int i = 0; i < 20; i++) send_bit(~lvl, OSR);
    check_acq("acq", 20);
    chk("locked_acq", bus.locked, 1'b1);

    // Frequency offset: fast then slow line.
    for (int i = 0; i < 30; i++) send_bit(~lvl, OSR - 1);
    chk("locked_fast", bus.locked, 1'b1);
    for (int i = 0; i < 30; i++) send_bit(~lvl, OSR + 1);
    chk("locked_slow", bus.locked, 1'b1);

    // Phase jump of 20 cycles, then reconvergence.
    for (int i = 0; i < 10; i++) send_bit(~lvl, OSR);
    send_bit(~lvl, OSR + 20);
    nv = ~lvl;
    repeat (4) tick(nv, 1'b1);
    chk("unlock_on_jump", bus.locked, 1'b0);
    repeat (OSR - 4) tick(nv, 1'b1);
    for (int i = 0; i < 40; i++) send_bit(~lvl, OSR);
    chk("relock", bus.locked, 1'b1);

    // Random data with +/-1 cycle period jitter.
    for (int i = 0; i < 40; i++)
      send_bit(1'($urandom_range(0, 1)), OSR - 1 + int'($urandom_range(0, 2)));

    // Edge timeout on a constant line.
    repeat (33 * OSR) tick(lvl, 1'b1);
    dv_q.delete();
    repeat (2 * OSR) tick(lvl, 1'b1);
    chk("dv_after_timeout", dv_q.size(), 0);
    chk("locked_timeout", bus.locked, 1'b0);

    // Re-acquire after timeout.
    dv_q.delete();
    t0 = cyc + 1;
    for (int i = 0; i < 12; i++) send_bit(~lvl, OSR);
    check_acq("reacq", 12);

    // Edge at the last phase, then an edge on the sample point.
    send_bit(~lvl, OSR - 1);
    for (int i = 0; i < 4; i++) send_bit(~lvl, OSR);
    send_bit(~lvl, HALF);
    for (int i = 0; i < 12; i++) send_bit(~lvl, OSR);

    // Enable dropped mid-bit while clk_rec is high.
    nv = ~lvl;
    repeat (70) tick(nv, 1'b1);
    tick(nv, 1'b0);
    chk("clk_rec_disable", bus.clk_rec, 1'b0);
    repeat (20) tick(nv, 1'b0);

    // Asynchronous reset mid-bit.
    for (int i = 0; i < 12; i++) send_bit(~lvl, OSR);
    nv = ~lvl;
    repeat (90) tick(nv, 1'b1);
    #2;
    reset = 1'b0;
    rst_drv = 1'b0;
    #1;
    chk("async_rst_valid", bus.data_valid, 1'b0);
    chk("async_rst_clk_rec", bus.clk_rec, 1'b0);
    chk("async_rst_locked", bus.locked, 1'b0);
    chk("async_rst_data", bus.data_out, 1'b0);
    model_clear();
    repeat (5) tick(nv, 1'b1);
    rst_drv = 1'b1;
    repeat (5) tick(nv, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(~lvl, OSR);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bit_sync.md
# bit_sync

Oversampling bit synchronizer and clock recoverer for the receive path. Takes an asynchronous NRZ serial line sampled at clk_1 with nominal bit period OSR clk_1 cycles (OSR=128 matches the transmit symbol clock clk_128). It tracks line transitions with a phase counter and emits mid-bit samples with a one-cycle valid strobe. It also produces a recovered symbol clock and a lock indication for downstream framing and demodulation logic.

## Interface
- OSR, 128: clk_1 cycles per bit; must be a power of two, ≥8.
- CNT_W, log2(OSR): phase counter width.
- TOL, 2: max |phase error| in cycles counted as an on-time edge.
- LOCK_CNT, 8: consecutive on-time edges required to assert locked.
- MAX_RUN, 32: bit periods without any edge before lock is dropped.
- clk_1  input  1  system sample clock.
- reset  input  1  asynchronous, active-low.
- enable  input  1  synchronous run enable.
- din  input  1  asynchronous serial line.
- data_out  output  1  sampled bit.
- data_valid  output  1  one-cycle strobe at each sample point.
- clk_rec  output  1  recovered symbol clock, 50% duty.
- locked  output  1  tracking lock indication.

## Operation
- Input path: 2-FF synchronizer gives din_s. din_d is din_s delayed one cycle. An edge is a cycle with din_s != din_d.
- phase: CNT_W-bit counter, modulo OSR (natural wrap). The ideal edge position is phase 0. The sample point is phase == OSR/2.
- States:
  - IDLE: entered on reset or whenever enable=0, from any state, on the next edge of clk_1. phase=0; all outputs 0; counters cleared.
  - ACQUIRE: entered from IDLE when enable=1. phase is held at 0 and no data_valid is issued. On the first edge, phase is hard-aligned: the edge cycle counts as phase 0, so phase=1 on the next cycle. The block then goes to TRACK.
  - TRACK: phase increments by 1 per cycle. On an edge at phase p, the error is e = p when p < OSR/2, and e = p − OSR otherwise.
    - e=0: normal increment.
    - e>0 (edge late): hold phase for one cycle.
    - e<0 (edge early): increment by 2. Wrap is modulo OSR, so an edge at p=OSR−1 gives next phase 1.
    - Correction is exactly 1 cycle per edge.
- data_valid is high for exactly the one cycle in which phase == OSR/2 in TRACK. data_out takes din_s in that same cycle and holds it until the next sample.
- clk_rec is 1 while phase ∈ [OSR/2, OSR−1] in TRACK, and 0 otherwise. Its rising edge coincides with the data_valid cycle. It is driven from a register.
- Lock tracking:
  - good_cnt increments on each edge with |e| ≤ TOL and saturates at LOCK_CNT.
  - An edge with |e| > TOL clears good_cnt and deasserts locked.
  - locked is asserted when good_cnt reaches LOCK_CNT.
- Edge timeout: run_cnt counts phase wraps and is cleared on every edge. When run_cnt reaches MAX_RUN, locked=0, good_cnt=0, and the state returns to ACQUIRE.
- Simultaneous events: an edge in the same cycle as phase == OSR/2 still issues data_valid and samples din_s, then applies the correction. An edge in the same cycle as the timeout: the edge wins and run_cnt clears.

## Timing
- Reset values: data_out=0, data_valid=0, clk_rec=0, locked=0, state=IDLE, phase=0.
- Assertion of reset mid-operation takes effect immediately (asynchronous). Deassertion resumes in IDLE.
- Latency: a din transition at cycle t is an edge at cycle t+2.
- The first data_valid after acquisition occurs at t+2+OSR/2 (t+66 for OSR=128).
- Steady state: data_valid period is exactly OSR cycles for an ideal input. Each correction lengthens (late edge) or shortens (early edge) one period by 1 cycle.
- Maximum trackable frequency offset: 1 cycle per edge interval.
- enable deassertion takes effect on the next clk_1 edge. No partial-bit output follows.

## Structure
- Shared package: the state enumeration (IDLE/ACQUIRE/TRACK) and the OSR and CNT_W defaults shared with the transmit clock generator.
- One natural sub-module, sync2_edge: the 2-FF synchronizer plus edge detector, reusable on other asynchronous inputs.
- The phase counter, the state machine and the lock/timeout counters stay in bit_sync.

## Test plan
- Reset/idle: hold reset low, then release with enable=0 and toggle din → all outputs stay 0, with no data_valid.
- Acquire: enable=1, then an alternating 1010… pattern at exactly 128 cycles/bit with the first din edge at cycle t → first data_valid at t+66, then every 128 cycles; data_out reproduces 1,0,1,0…; clk_rec rises on each data_valid cycle; locked asserts after the 8th on-time edge.
- Frequency offset: input bit period 127 cycles, then 129 cycles → the counter applies early/late corrections; data_valid stays within ±2 cycles of mid-bit; locked stays 1.
- Phase jump: a steady locked stream followed by a 20-cycle shift of all edges → locked drops on the first misaligned edge. Phase converges at 1 cycle per edge, and locked returns after 8 edges within TOL.
- Timeout: while locked, hold din constant for 32 bit periods → locked falls and the state returns to ACQUIRE with no further data_valid. The next edge re-acquires, with the first data_valid 64 cycles after that edge.
- Boundary/mid-op: an edge exactly at phase 127 gives next phase 1, and an edge at phase 64 still produces data_valid. Asserting reset or deasserting enable mid-bit clears all outputs immediately or on the next cycle respectively.
